regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single write port of register_file (write/rd/reg_write) between two writeback requesters: the ALU result path and the memory load path.
- Arbitration is round-robin with a valid/ready handshake.
- Granted writes are registered onto the register-file write port.
- A per-register pending scoreboard drives a decode-stage stall for RAW hazards until the write commits.
- Sits between execute/memory stages and register_file; rs1/rs2 are the same indices decode drives into register_file.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers, index 0 is hardwired zero

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_rd  in  ADDR_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  load writeback request
mem_rd  in  ADDR_WIDTH  load destination register
mem_data  in  DATA_WIDTH  load data
mem_ready  out  1  load request accepted this cycle
issue_valid  in  1  decode issuing an instruction that will write issue_rd
issue_rd  in  ADDR_WIDTH  destination being reserved
rs1  in  ADDR_WIDTH  decode source 1 index
rs2  in  ADDR_WIDTH  decode source 2 index
stall  out  1  rs1 or rs2 has an uncommitted pending write
write  out  1  register_file write enable (registered)
rd  out  ADDR_WIDTH  register_file write index (registered)
reg_write  out  DATA_WIDTH  register_file write data (registered)

Behaviour:
- Reset (async, while rst=1):
  - write=0, rd=0, reg_write=0.
  - pending[all]=0.
  - last_grant=MEM, so the first tie goes to ALU.
  - alu_ready=0, mem_ready=0, stall=0.
- Handshake:
  - Requester holds valid, rd and data stable until it sees ready=1.
  - Transfer occurs at the rising edge where valid&ready=1.
  - ready is combinational from the valid inputs and last_grant; it is never asserted without the matching valid.
- Grant:
  - Only one valid: grant it.
  - Both valid: grant the requester not in last_grant.
  - Neither valid: no grant; last_grant holds.
  - last_grant updates to the granted requester on each transfer.
  - Exactly one transfer per cycle maximum.
- Output stage, 1-cycle latency:
  - On a transfer edge: write<=1, rd<=granted rd, reg_write<=granted data.
  - Otherwise write<=0; rd and reg_write hold their last values.
- x0 suppression:
  - A granted request with rd=0 completes its handshake normally (ready=1) and updates last_grant.
  - It produces write<=0 at the output.
- Scoreboard, pending bit per register:
  - Set: at an edge with issue_valid=1 and issue_rd!=0, pending[issue_rd]<=1.
  - Clear: at an edge with write=1, pending[rd]<=0. This is the same edge register_file commits the write.
  - Set and clear of the same register on the same edge: set wins. The new instruction's reservation survives.
  - pending[0] is always 0.
- stall (combinational) = pending[rs1] | pending[rs2].
  - After the commit edge, stall drops in the same cycle register_file returns the new value on reg1/reg2.
- Writes to a non-pending register are legal and need no reservation.
- Reset mid-transfer discards the in-flight write (write=0) and clears all pending bits.
  - The requester must re-present the request after reset.
- Back-to-back grants are allowed every cycle with no bubble.

Test Plan:
- Reset: assert rst=1 mid-cycle with random inputs -> write=0, rd=0, reg_write=0, stall=0 immediately, without waiting for a clk edge.
- Single ALU write: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF -> alu_ready=1 that cycle; next cycle write=1, rd=3, reg_write=0xDEADBEEF; following cycle write=0.
- Tie/round-robin: both valid for 4 cycles (alu_rd=1/data=0x11, mem_rd=2/data=0x22), each dropping valid after accept then re-asserting -> grants ALU, MEM, ALU, MEM; rd sequence 1,2,1,2.
- x0 write: mem_valid=1, mem_rd=0, mem_data=0xFFFFFFFF -> mem_ready=1; next cycle write=0; register 0 remains 0 in register_file.
- Scoreboard: issue_valid=1, issue_rd=5, then rs1=5 -> stall=1. Deliver alu_rd=5 two cycles later -> stall stays 1 through the cycle write=1, then 0 after that edge; reg1 reads the new data.
- Set/clear collision: pending[7]=1 and write=1/rd=7 on the same edge as issue_valid=1/issue_rd=7 -> pending[7] remains 1; stall=1 with rs2=7.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback requesters, decode scoreboard taps and register_file write port
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;
  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  stall;
  logic                  write;
  logic [ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] reg_write;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd, rs1, rs2,
    input  alu_ready, mem_ready, stall, write, rd, reg_write
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd, rs1, rs2,
    output alu_ready, mem_ready, stall, write, rd, reg_write
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register_file write port with a RAW pending scoreboard
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic clk,
  input logic rst,
  regfile_write_arbiter_if.slave bus
);
  typedef enum logic {ALU, MEM} grant_t;
  grant_t last_grant, last_grant_nxt;
  logic [2**ADDR_WIDTH-1:0] pending, pending_nxt;
  logic [ADDR_WIDTH-1:0] g_rd;
  logic [DATA_WIDTH-1:0] g_data;
  logic xfer;
  // On a tie the requester not served last wins; ready only follows its own valid
  assign bus.alu_ready = !rst && bus.alu_valid && (!bus.mem_valid || last_grant == MEM);
  assign bus.mem_ready = !rst && bus.mem_valid && (!bus.alu_valid || last_grant == ALU);
  assign xfer = bus.alu_ready || bus.mem_ready;
  assign g_rd = bus.alu_ready ? bus.alu_rd : bus.mem_rd;
  assign g_data = bus.alu_ready ? bus.alu_data : bus.mem_data;
  assign bus.stall = pending[bus.rs1] | pending[bus.rs2];
  // Next round-robin owner and scoreboard update; a new reservation beats a same-edge commit
  always_comb begin
    last_grant_nxt = bus.alu_ready ? ALU : bus.mem_ready ? MEM : last_grant;
    pending_nxt = pending;
    if (bus.write) pending_nxt[bus.rd] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != '0) pending_nxt[bus.issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end
  // State registers; reset leaves MEM as last owner so the first tie goes to ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= MEM;
      pending <= '0;
    end else begin
      last_grant <= last_grant_nxt;
      pending <= pending_nxt;
    end
  end
  // Registered write port; writes to x0 complete the handshake but never assert write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.write <= 1'b0;
      bus.rd <= '0;
      bus.reg_write <= '0;
    end else if (xfer) begin
      bus.write <= g_rd != '0;
      bus.rd <= g_rd;
      bus.reg_write <= g_data;
    end else begin
      bus.write <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random checks of the write arbiter against a behavioural model
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  bit pend [32];
  bit m_last_alu;
  logic m_write;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  int last_win;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    m_last_alu = 1'b0;
    m_write = 1'b0;
    m_rd = '0;
    m_data = '0;
    last_win = 0;
  endtask
  task automatic idle_inputs();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
  endtask
  task automatic tick();
    int win;
    #1;
    win = (bus.alu_valid && bus.mem_valid) ? (m_last_alu ? 2 : 1) : bus.alu_valid ? 1 : bus.mem_valid ? 2 : 0;
    check("alu_ready", bus.alu_ready, win == 1);
    check("mem_ready", bus.mem_ready, win == 2);
    check("stall", bus.stall, pend[bus.rs1] || pend[bus.rs2]);
    if (m_write) pend[m_rd] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != 0) pend[bus.issue_rd] = 1'b1;
    if (win != 0) begin
      m_last_alu = win == 1;
      m_rd = win == 1 ? bus.alu_rd : bus.mem_rd;
      m_data = win == 1 ? bus.alu_data : bus.mem_data;
      m_write = m_rd != 0;
    end else m_write = 1'b0;
    last_win = win;
    @(posedge clk);
    #1;
    check("write", bus.write, m_write);
    check("rd", bus.rd, m_rd);
    check("reg_write", bus.reg_write, m_data);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_write", bus.write, 0);
    check("rst_rd", bus.rd, 0);
    check("rst_reg_write", bus.reg_write, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_ready", {bus.alu_ready, bus.mem_ready}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int seq [4];
    idle_inputs();
    model_reset();
    #2;
    do_reset();
    // single ALU write
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'hDEADBEEF;
    #1 check("single_ready", bus.alu_ready, 1);
    tick();
    check("single_write", {bus.write, bus.rd, bus.reg_write}, {1'b1, 5'd3, 32'hDEADBEEF});
    bus.alu_valid = 0;
    tick();
    check("single_drop", bus.write, 0);
    // round robin from a fresh reset: ALU, MEM, ALU, MEM
    do_reset();
    bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h11;
    bus.mem_valid = 1; bus.mem_rd = 2; bus.mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      seq[i] = int'(bus.rd);
    end
    check("rr_seq", {seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0]}, 16'h1212);
    idle_inputs();
    tick();
    // x0 write completes handshake but never asserts write
    bus.mem_valid = 1; bus.mem_rd = 0; bus.mem_data = 32'hFFFFFFFF;
    #1 check("x0_ready", bus.mem_ready, 1);
    tick();
    check("x0_write", bus.write, 0);
    bus.mem_valid = 0;
    tick();
    // scoreboard: reserve x5, deliver later, stall holds through the commit cycle
    bus.issue_valid = 1; bus.issue_rd = 5;
    tick();
    bus.issue_valid = 0; bus.rs1 = 5;
    #1 check("sb_stall_set", bus.stall, 1);
    tick();
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hCAFE0005;
    tick();
    bus.alu_valid = 0;
    check("sb_commit_write", bus.write, 1);
    check("sb_stall_commit", bus.stall, 1);
    tick();
    check("sb_stall_clear", bus.stall, 0);
    // set and clear of x7 on the same edge: reservation survives
    bus.rs1 = 0;
    bus.issue_valid = 1; bus.issue_rd = 7;
    tick();
    bus.issue_valid = 0; bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'h7;
    tick();
    bus.alu_valid = 0; bus.issue_valid = 1; bus.issue_rd = 7; bus.rs2 = 7;
    check("col_write", {bus.write, bus.rd}, {1'b1, 5'd7});
    tick();
    bus.issue_valid = 0;
    #1 check("col_stall", bus.stall, 1);
    tick();
    // random traffic; requesters hold their request until accepted
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      if (!bus.alu_valid || last_win == 1) begin
        bus.alu_valid = $urandom_range(0, 1) == 1;
        bus.alu_rd = AW'($urandom_range(0, 7));
        bus.alu_data = $urandom;
      end
      if (!bus.mem_valid || last_win == 2) begin
        bus.mem_valid = $urandom_range(0, 2) == 0;
        bus.mem_rd = AW'($urandom_range(0, 7));
        bus.mem_data = $urandom;
      end
      bus.issue_valid = $urandom_range(0, 3) == 0;
      bus.issue_rd = AW'($urandom_range(0, 7));
      bus.rs1 = AW'($urandom_range(0, 7));
      bus.rs2 = AW'($urandom_range(0, 7));
      tick();
    end
    // mid-cycle reset with random live inputs
    bus.alu_valid = 1; bus.mem_valid = 1; bus.alu_rd = 4; bus.mem_rd = 6;
    bus.issue_valid = 1; bus.issue_rd = 3;
    for (int i = 1; i < 8; i++) if (pend[i]) bus.rs1 = AW'(i);
    #2;
    do_reset();
    idle_inputs();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
